// File: rtl/serial_launch_tx_pkg.sv
// Shared types and sizing helpers for the serial launcher.
// Optional parity stage is selected by SERIAL_LAUNCH_TX_PARITY_EN in the top module.
package serial_launch_tx_pkg;

  localparam int MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_e;

  // A one-bit frame still needs a one-bit counter.
  function automatic int CNT_W(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_launch_shreg.sv
// Load/shift register; o_bit is the next outgoing bit (taken from i_data on a load cycle).
// Shifts once on load, so the register always holds the bits still to be sent after o_bit.
module serial_launch_shreg
  import serial_launch_tx_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_bit
);

  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] w_src;

  assign w_src = i_load ? i_data : r_sh;
  assign o_bit = MSB_FIRST ? w_src[WIDTH-1] : w_src[0];

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_sh <= '0;
    end else if (i_load || i_shift) begin
      r_sh <= MSB_FIRST ? (w_src << 1) : (w_src >> 1);
    end
  end

endmodule

// File: rtl/serial_launch_tx.sv
// Valid/ready parallel-in, serial-out launcher: first bit on sdo one CK after accept, gapless back-to-back.
// load_ready only in IDLE or the frame's final cycle; SERIAL_LAUNCH_TX_PARITY_EN appends an even-parity bit.
module serial_launch_tx
  import serial_launch_tx_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             sdo,
  output logic             sdo_en,
  output logic             busy,
  output logic             done
);

  localparam int CW = CNT_W(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e          r_state;
  state_e          w_next_state;
  logic [CW-1:0]   r_cnt;
  logic            r_sdo;
  logic            r_sdo_en;
  logic            w_accept;
  logic            w_shift;
  logic            w_last;
  logic            w_next_bit;
  logic            w_sdo_d;
  logic            w_sdo_en_d;

  assign w_accept = load_valid && load_ready;
  assign w_last   = (r_state == SHIFT) && (r_cnt == '0);
  assign busy     = (r_state != IDLE);
  assign sdo      = r_sdo;
  assign sdo_en   = r_sdo_en;

  serial_launch_shreg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .CK      (CK),
    .RN      (RN),
    .i_load  (w_accept),
    .i_shift (w_shift),
    .i_data  (load_data),
    .o_bit   (w_next_bit)
  );

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    load_ready   = 1'b0;
    done         = 1'b0;
    w_shift      = 1'b0;
    case (r_state)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) w_next_state = SHIFT;
      end
      SHIFT: begin
        if (r_cnt != '0) begin
          w_shift = 1'b1;
        end else begin
`ifdef SERIAL_LAUNCH_TX_PARITY_EN
          w_next_state = PAR;
`else
          done         = 1'b1;
          load_ready   = 1'b1;
          w_next_state = load_valid ? SHIFT : IDLE;
`endif
        end
      end
`ifdef SERIAL_LAUNCH_TX_PARITY_EN
      PAR: begin
        done         = 1'b1;
        load_ready   = 1'b1;
        w_next_state = load_valid ? SHIFT : IDLE;
      end
`endif
      default: w_next_state = IDLE;
    endcase
  end

`ifdef SERIAL_LAUNCH_TX_PARITY_EN
  logic r_par;

  // Running XOR of every bit already placed on sdo in this frame.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_par <= 1'b0;
    end else if (w_accept) begin
      r_par <= w_next_bit;
    end else if (w_shift) begin
      r_par <= r_par ^ w_next_bit;
    end
  end
`endif

  always_comb begin
    w_sdo_d    = 1'b0;
    w_sdo_en_d = 1'b0;
    if (w_accept || w_shift) begin
      w_sdo_d    = w_next_bit;
      w_sdo_en_d = 1'b1;
    end
`ifdef SERIAL_LAUNCH_TX_PARITY_EN
    else if (w_last) begin
      w_sdo_d    = r_par;
      w_sdo_en_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_cnt    <= '0;
      r_sdo    <= 1'b0;
      r_sdo_en <= 1'b0;
    end else begin
      r_sdo    <= w_sdo_d;
      r_sdo_en <= w_sdo_en_d;
      if (w_accept) begin
        r_cnt <= CNT_LAST;
      end else if (w_shift) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

endmodule
